// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage sequencer. Accepts one op from the pipeline,
// issues a data-bus request built from the helper's pre-aligned fields, and
// returns the load result to writeback after sign/zero extension.
module mem_access_unit #(
   parameter int unsigned BUS_LATENCY_MAX = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_addr,
   input  logic [3:0]  in_mode,
   input  logic [63:0] hlp_addr,
   input  logic [2:0]  hlp_size,
   input  logic [7:0]  hlp_strobe,
   input  logic [63:0] hlp_data,
   output logic        dbus_valid,
   output logic [63:0] dbus_addr,
   output logic [2:0]  dbus_size,
   output logic [7:0]  dbus_strobe,
   output logic [63:0] dbus_data,
   input  logic        dbus_data_ok,
   input  logic [63:0] dbus_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        out_misalign,
   output logic        out_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        in_ready_q, in_ready_d;
   logic [3:0]  mode_q, mode_d;
   logic [2:0]  off_q, off_d;
   logic        dbus_valid_q, dbus_valid_d;
   logic [63:0] dbus_addr_q, dbus_addr_d;
   logic [2:0]  dbus_size_q, dbus_size_d;
   logic [7:0]  dbus_strobe_q, dbus_strobe_d;
   logic [63:0] dbus_data_q, dbus_data_d;
   logic        out_valid_q, out_valid_d;
   logic [63:0] out_data_q, out_data_d;
   logic        out_misalign_q, out_misalign_d;
   logic        out_err_q, out_err_d;
   logic [31:0] wdog_q, wdog_d;

   // True for the load/store encodings; everything else bypasses the bus.
   function automatic logic is_mem(input logic [3:0] m);
      logic r;
      case (m)
         4'b0000, 4'b0001, 4'b0010, 4'b0011,
         4'b0100, 4'b0101, 4'b0110,
         4'b1000, 4'b1001, 4'b1010, 4'b1011: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   // Access width is encoded in mode[1:0] for every memory encoding.
   function automatic logic is_misaligned(input logic [3:0] m, input logic [2:0] o);
      logic r;
      case (m[1:0])
         2'b01:   r = (o[0] != 1'b0);
         2'b10:   r = (o[1:0] != 2'b00);
         2'b11:   r = (o != 3'b000);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Shift the addressed lane down to bit 0, then extend by access type.
   function automatic logic [63:0] extract(input logic [3:0] m, input logic [2:0] o,
                                           input logic [63:0] rd);
      logic [63:0] sh;
      logic [63:0] r;
      sh = rd >> {o, 3'b000};
      case (m)
         4'b0000: r = {{56{sh[7]}},  sh[7:0]};
         4'b0001: r = {{48{sh[15]}}, sh[15:0]};
         4'b0010: r = {{32{sh[31]}}, sh[31:0]};
         4'b0011: r = sh;
         4'b0100: r = {56'd0, sh[7:0]};
         4'b0101: r = {48'd0, sh[15:0]};
         4'b0110: r = {32'd0, sh[31:0]};
         default: r = 64'd0;
      endcase
      return r;
   endfunction

   // Next-state and next-output computation for the IDLE/BUS/DONE sequencer.
   always_comb begin
      state_d        = state_q;
      in_ready_d     = in_ready_q;
      mode_d         = mode_q;
      off_d          = off_q;
      dbus_valid_d   = dbus_valid_q;
      dbus_addr_d    = dbus_addr_q;
      dbus_size_d    = dbus_size_q;
      dbus_strobe_d  = dbus_strobe_q;
      dbus_data_d    = dbus_data_q;
      out_valid_d    = out_valid_q;
      out_data_d     = out_data_q;
      out_misalign_d = out_misalign_q;
      out_err_d      = out_err_q;
      wdog_d         = wdog_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               mode_d     = in_mode;
               off_d      = in_addr[2:0];
               in_ready_d = 1'b0;
               wdog_d     = 32'd0;
               if (is_mem(in_mode) && !is_misaligned(in_mode, in_addr[2:0])) begin
                  state_d       = ST_BUS;
                  dbus_valid_d  = 1'b1;
                  dbus_addr_d   = hlp_addr;
                  dbus_size_d   = hlp_size;
                  // Loads are reads: the strobe must be zero regardless of helper.
                  dbus_strobe_d = in_mode[3] ? hlp_strobe : 8'h00;
                  dbus_data_d   = hlp_data;
               end else begin
                  state_d        = ST_DONE;
                  out_valid_d    = 1'b1;
                  out_misalign_d = is_mem(in_mode);
                  out_err_d      = 1'b0;
                  out_data_d     = is_mem(in_mode) ? 64'd0 : in_addr;
               end
            end else begin
               in_ready_d = 1'b1;
            end
         end
         ST_BUS: begin
            if (dbus_data_ok) begin
               state_d        = ST_DONE;
               dbus_valid_d   = 1'b0;
               dbus_addr_d    = 64'd0;
               dbus_size_d    = 3'd0;
               dbus_strobe_d  = 8'h00;
               dbus_data_d    = 64'd0;
               out_valid_d    = 1'b1;
               out_misalign_d = 1'b0;
               out_err_d      = 1'b0;
               out_data_d     = mode_q[3] ? 64'd0 : extract(mode_q, off_q, dbus_rdata);
            end else if ((BUS_LATENCY_MAX != 32'd0) && ((wdog_q + 32'd1) == BUS_LATENCY_MAX)) begin
               state_d        = ST_DONE;
               dbus_valid_d   = 1'b0;
               dbus_addr_d    = 64'd0;
               dbus_size_d    = 3'd0;
               dbus_strobe_d  = 8'h00;
               dbus_data_d    = 64'd0;
               out_valid_d    = 1'b1;
               out_misalign_d = 1'b0;
               out_err_d      = 1'b1;
               out_data_d     = 64'd0;
               wdog_d         = wdog_q + 32'd1;
            end else begin
               wdog_d = wdog_q + 32'd1;
            end
         end
         ST_DONE: begin
            // in_ready stays low here so a new op waits for the next IDLE cycle.
            if (out_ready) begin
               state_d        = ST_IDLE;
               in_ready_d     = 1'b1;
               out_valid_d    = 1'b0;
               out_data_d     = 64'd0;
               out_misalign_d = 1'b0;
               out_err_d      = 1'b0;
               wdog_d         = 32'd0;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d        = ST_IDLE;
            in_ready_d     = 1'b1;
            dbus_valid_d   = 1'b0;
            out_valid_d    = 1'b0;
            out_data_d     = 64'd0;
            out_misalign_d = 1'b0;
            out_err_d      = 1'b0;
            wdog_d         = 32'd0;
         end
      endcase
   end

   // State and registered-output flops; reset drops any in-flight request or result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         in_ready_q     <= 1'b1;
         mode_q         <= 4'd0;
         off_q          <= 3'd0;
         dbus_valid_q   <= 1'b0;
         dbus_addr_q    <= 64'd0;
         dbus_size_q    <= 3'd0;
         dbus_strobe_q  <= 8'h00;
         dbus_data_q    <= 64'd0;
         out_valid_q    <= 1'b0;
         out_data_q     <= 64'd0;
         out_misalign_q <= 1'b0;
         out_err_q      <= 1'b0;
         wdog_q         <= 32'd0;
      end else begin
         state_q        <= state_d;
         in_ready_q     <= in_ready_d;
         mode_q         <= mode_d;
         off_q          <= off_d;
         dbus_valid_q   <= dbus_valid_d;
         dbus_addr_q    <= dbus_addr_d;
         dbus_size_q    <= dbus_size_d;
         dbus_strobe_q  <= dbus_strobe_d;
         dbus_data_q    <= dbus_data_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         out_misalign_q <= out_misalign_d;
         out_err_q      <= out_err_d;
         wdog_q         <= wdog_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign dbus_valid   = dbus_valid_q;
   assign dbus_addr    = dbus_addr_q;
   assign dbus_size    = dbus_size_q;
   assign dbus_strobe  = dbus_strobe_q;
   assign dbus_data    = dbus_data_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_misalign = out_misalign_q;
   assign out_err      = out_err_q;

endmodule
